// File: rtl/fsm_pkg.sv
// Shared FSM state encoding, used by the monitored FSM blocks and by the state monitor.
// Event record layout is {lane, from, to}; STATE_W is the width of one state field.
package fsm_pkg;

    typedef enum logic [1:0] {
        A = 2'd0,
        B = 2'd1,
        C = 2'd2,
        D = 2'd3
    } state_t;

    localparam int STATE_W = 2;

    function automatic int evt_width(input int num_fsm);
        return $clog2(num_fsm) + 2 * STATE_W;
    endfunction

endpackage

// File: rtl/fsm_state_monitor_if.sv
// Transition-event stream: valid/ready handshake carrying {lane, from, to}.
// The head event holds steady while valid is high and ready is low.
interface fsm_state_monitor_if #(
    parameter int P_NUM_FSM = 8
);
    localparam int LANE_W = $clog2(P_NUM_FSM);

    logic               O_EVT_VALID;
    logic               I_EVT_READY;
    logic [LANE_W-1:0]  O_EVT_LANE;
    fsm_pkg::state_t    O_EVT_FROM;
    fsm_pkg::state_t    O_EVT_TO;

    modport master (
        output O_EVT_VALID, O_EVT_LANE, O_EVT_FROM, O_EVT_TO,
        input  I_EVT_READY
    );

    modport slave (
        input  O_EVT_VALID, O_EVT_LANE, O_EVT_FROM, O_EVT_TO,
        output I_EVT_READY
    );
endinterface

// File: rtl/evt_fifo.sv
// Registered-head FIFO: a push is visible at the head one cycle later; pop on vld_o && pop_i.
// The push is dropped when full; a same-cycle pop does not make room for it.
module evt_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push_i,
    input  logic [P_WIDTH-1:0] push_dat_i,
    input  logic               pop_i,
    output logic [P_WIDTH-1:0] head_dat_o,
    output logic               vld_o,
    output logic               full_o
);
    localparam int AW = $clog2(P_DEPTH);

    logic [P_DEPTH-1:0][P_WIDTH-1:0] mem_q;
    logic [AW-1:0]                   wr_ptr_q;
    logic [AW-1:0]                   rd_ptr_q;
    logic [AW:0]                     cnt_q;
    logic                            do_push;
    logic                            do_pop;

    assign vld_o      = (cnt_q != '0);
    assign full_o     = (cnt_q == (AW+1)'(P_DEPTH));
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && vld_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fsm_state_monitor.sv
// Watches P_NUM_FSM state lanes, queues transition events (2-cycle latency when idle) and flags lanes
// that dwell too long. A full FIFO stalls the arbiter; further changes on a stalled lane are coalesced.
module fsm_state_monitor
    import fsm_pkg::*;
#(
    parameter int P_NUM_FSM    = 8,
    parameter int P_DWELL_W    = 8,
    parameter int P_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  state_t [P_NUM_FSM-1:0]       I_STATE,
    input  logic   [P_DWELL_W-1:0]       I_STUCK_LIMIT,
    input  logic                         I_CLR,
    fsm_state_monitor_if.master          evt,
    output logic   [P_NUM_FSM-1:0]       O_STUCK,
    output logic                         O_OVERFLOW
);
    localparam int LANE_W = $clog2(P_NUM_FSM);
    localparam int EVT_W  = evt_width(P_NUM_FSM);

    state_t [P_NUM_FSM-1:0]                 prev_q;
    logic   [P_NUM_FSM-1:0]                 pend_q,  pend_d;
    state_t [P_NUM_FSM-1:0]                 from_q,  from_d;
    state_t [P_NUM_FSM-1:0]                 to_q,    to_d;
    logic   [P_NUM_FSM-1:0][P_DWELL_W-1:0]  dwell_q, dwell_d;
    logic   [P_NUM_FSM-1:0]                 stuck_q, stuck_d;
    logic                                   ovf_q,   ovf_d;
    logic   [LANE_W-1:0]                    ptr_q,   ptr_d;

    logic   [P_NUM_FSM-1:0]                 chg;
    logic   [P_NUM_FSM-1:0]                 gnt_oh;
    logic                                   gnt_vld;
    logic   [LANE_W-1:0]                    gnt_lane;
    logic                                   fifo_full;
    logic   [EVT_W-1:0]                     push_dat;
    logic   [EVT_W-1:0]                     head_dat;

    always_comb begin
        chg = '0;
        for (int i = 0; i < P_NUM_FSM; i++) begin
            chg[i] = (I_STATE[i] != prev_q[i]);
        end
    end

    // Round-robin search starting at ptr_q; nothing is granted while the FIFO is full.
    always_comb begin
        int                sum;
        logic [LANE_W-1:0] idx;
        gnt_vld  = 1'b0;
        gnt_lane = '0;
        gnt_oh   = '0;
        ptr_d    = ptr_q;
        for (int k = 0; k < P_NUM_FSM; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= P_NUM_FSM) begin
                sum = sum - P_NUM_FSM;
            end
            idx = LANE_W'(sum);
            if (!fifo_full && !gnt_vld && pend_q[idx]) begin
                gnt_vld     = 1'b1;
                gnt_lane    = idx;
                gnt_oh[idx] = 1'b1;
                ptr_d       = (idx == LANE_W'(P_NUM_FSM - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_comb begin
        logic ovf_set;
        pend_d  = pend_q;
        from_d  = from_q;
        to_d    = to_q;
        dwell_d = dwell_q;
        stuck_d = stuck_q;
        ovf_set = 1'b0;
        for (int i = 0; i < P_NUM_FSM; i++) begin
            if (chg[i]) begin
                // A lane that keeps its slot across a change only moves its TO; the lost hop is flagged.
                if (pend_q[i] && !gnt_oh[i]) begin
                    to_d[i] = I_STATE[i];
                    ovf_set = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    from_d[i] = prev_q[i];
                    to_d[i]   = I_STATE[i];
                end
            end else if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end

            if (chg[i]) begin
                dwell_d[i] = '0;
            end else if (dwell_q[i] != '1) begin
                dwell_d[i] = dwell_q[i] + P_DWELL_W'(1);
            end

            if (chg[i] || I_CLR) begin
                stuck_d[i] = 1'b0;
            end else if ((I_STUCK_LIMIT != '0) && (dwell_q[i] >= I_STUCK_LIMIT)) begin
                stuck_d[i] = 1'b1;
            end
        end
        ovf_d = I_CLR ? 1'b0 : (ovf_q | ovf_set);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < P_NUM_FSM; i++) begin
                prev_q[i] <= A;
                from_q[i] <= A;
                to_q[i]   <= A;
            end
            pend_q  <= '0;
            dwell_q <= '0;
            stuck_q <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            prev_q  <= I_STATE;
            pend_q  <= pend_d;
            from_q  <= from_d;
            to_q    <= to_d;
            dwell_q <= dwell_d;
            stuck_q <= stuck_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
        end
    end

    assign push_dat = {gnt_lane, from_q[gnt_lane], to_q[gnt_lane]};

    evt_fifo #(
        .P_WIDTH (EVT_W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_evt_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (gnt_vld),
        .push_dat_i (push_dat),
        .pop_i      (evt.I_EVT_READY),
        .head_dat_o (head_dat),
        .vld_o      (evt.O_EVT_VALID),
        .full_o     (fifo_full)
    );

    assign evt.O_EVT_LANE = head_dat[EVT_W-1 -: LANE_W];
    assign evt.O_EVT_FROM = state_t'(head_dat[2*STATE_W-1 -: STATE_W]);
    assign evt.O_EVT_TO   = state_t'(head_dat[STATE_W-1:0]);
    assign O_STUCK        = stuck_q;
    assign O_OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Bench for fsm_state_monitor: expected events are queued when lanes are driven and
// checked in order as the DUT hands them over; flags and latency are checked directly.
module tb_fsm_state_monitor;
    import fsm_pkg::*;

    localparam int NL = 8;

    logic              clk = 1'b0;
    logic              rstn;
    state_t [NL-1:0]   st;
    logic   [7:0]      lim;
    logic              clr;
    logic   [NL-1:0]   stuck;
    logic              ovf;

    int                n_vec = 0;
    int                n_err = 0;
    logic   [6:0]      sb_q[$];

    fsm_state_monitor_if #(.P_NUM_FSM(NL)) evt_if ();

    fsm_state_monitor #(
        .P_NUM_FSM    (NL),
        .P_DWELL_W    (8),
        .P_FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .I_STATE       (st),
        .I_STUCK_LIMIT (lim),
        .I_CLR         (clr),
        .evt           (evt_if.master),
        .O_STUCK       (stuck),
        .O_OVERFLOW    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ev(input int lane, input state_t f, input state_t t);
        return {3'(lane), f, t};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (sb_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain", sb_q.size(), 0);
        @(negedge clk);
        chk("drain_idle", evt_if.O_EVT_VALID, 1'b0);
    endtask

    // Every accepted event must be the next one expected.
    always @(negedge clk) begin
        if (rstn === 1'b1 && evt_if.O_EVT_VALID === 1'b1 && evt_if.I_EVT_READY === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("evt_unexpected", evt_if.O_EVT_VALID, 1'b0);
            end else begin
                chk("evt", {evt_if.O_EVT_LANE, evt_if.O_EVT_FROM, evt_if.O_EVT_TO}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t, limit 100000", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        rstn = 1'b0;
        for (int i = 0; i < NL; i++) st[i] = A;
        lim = 8'd0;
        clr = 1'b0;
        evt_if.I_EVT_READY = 1'b1;

        @(negedge clk);
        chk("rst_valid", evt_if.O_EVT_VALID, 1'b0);
        chk("rst_lane",  evt_if.O_EVT_LANE, 3'd0);
        chk("rst_from",  evt_if.O_EVT_FROM, A);
        chk("rst_to",    evt_if.O_EVT_TO, A);
        chk("rst_stuck", stuck, 8'h00);
        chk("rst_ovf",   ovf, 1'b0);
        tick(2);
        rstn = 1'b1;

        // Idle lanes with detection disabled stay quiet.
        repeat (30) @(negedge clk);
        chk("idle_valid", evt_if.O_EVT_VALID, 1'b0);
        chk("idle_stuck", stuck, 8'h00);

        // Three lanes at once from pointer 0.
        tick(1);
        st[0] = B; st[2] = B; st[5] = B;
        sb_q.push_back(ev(0, A, B));
        sb_q.push_back(ev(2, A, B));
        sb_q.push_back(ev(5, A, B));
        @(negedge clk); chk("rr_n0", evt_if.O_EVT_VALID, 1'b0);
        @(negedge clk); chk("rr_n1", evt_if.O_EVT_VALID, 1'b0);
        @(negedge clk); chk("rr_first",  {evt_if.O_EVT_VALID, evt_if.O_EVT_LANE}, {1'b1, 3'd0});
        @(negedge clk); chk("rr_second", {evt_if.O_EVT_VALID, evt_if.O_EVT_LANE}, {1'b1, 3'd2});
        @(negedge clk); chk("rr_third",  {evt_if.O_EVT_VALID, evt_if.O_EVT_LANE}, {1'b1, 3'd5});
        @(negedge clk); chk("rr_done", evt_if.O_EVT_VALID, 1'b0);

        // Lane 0 alone moves the pointer to 1, so lane 1 then wins over lane 0.
        tick(1);
        st[0] = C;
        sb_q.push_back(ev(0, B, C));
        wait_drain(20);
        tick(1);
        st[0] = D; st[1] = B;
        sb_q.push_back(ev(1, A, B));
        sb_q.push_back(ev(0, C, D));
        wait_drain(20);

        // Single lane: valid exactly two cycles after the change, for one cycle.
        tick(1);
        st[3] = B;
        sb_q.push_back(ev(3, A, B));
        @(negedge clk); chk("lat_n0", evt_if.O_EVT_VALID, 1'b0);
        @(negedge clk); chk("lat_n1", evt_if.O_EVT_VALID, 1'b0);
        @(negedge clk); chk("lat_n2", {evt_if.O_EVT_VALID, evt_if.O_EVT_LANE}, {1'b1, 3'd3});
        @(negedge clk); chk("lat_n3", evt_if.O_EVT_VALID, 1'b0);

        // Backpressure: fill the FIFO, then coalesce on stalled lanes.
        tick(1);
        rstn = 1'b0;
        for (int i = 0; i < NL; i++) st[i] = A;
        tick(2);
        rstn = 1'b1;
        evt_if.I_EVT_READY = 1'b0;
        tick(1);
        for (int i = 2; i < NL; i++) st[i] = B;
        for (int i = 2; i < 6; i++) sb_q.push_back(ev(i, A, B));
        tick(6);
        st[6] = C;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk); chk("ovf_clr_prio", ovf, 1'b0);
        tick(1);
        st[0] = B;
        tick(1);
        st[0] = C;
        @(negedge clk); chk("ovf_pre", ovf, 1'b0);
        @(negedge clk); chk("ovf_set", ovf, 1'b1);
        chk("hold_head", {evt_if.O_EVT_VALID, evt_if.O_EVT_LANE, evt_if.O_EVT_FROM, evt_if.O_EVT_TO},
            {1'b1, ev(2, A, B)});
        repeat (3) @(negedge clk);
        chk("hold_head_later", {evt_if.O_EVT_VALID, evt_if.O_EVT_LANE, evt_if.O_EVT_FROM, evt_if.O_EVT_TO},
            {1'b1, ev(2, A, B)});
        sb_q.push_back(ev(6, A, C));
        sb_q.push_back(ev(7, A, B));
        sb_q.push_back(ev(0, A, C));
        tick(1);
        evt_if.I_EVT_READY = 1'b1;
        wait_drain(40);
        chk("ovf_sticky", ovf, 1'b1);
        tick(1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk); chk("ovf_cleared", ovf, 1'b0);

        // Stuck detection with limit 5.
        tick(1);
        lim = 8'd5;
        tick(10);
        @(negedge clk); chk("stuck_all", stuck, 8'hFF);
        tick(1);
        st[7] = C;
        sb_q.push_back(ev(7, B, C));
        @(negedge clk);
        @(negedge clk); chk("stuck_chg_clr", stuck, 8'h7F);
        repeat (2) @(negedge clk); chk("stuck_dwell_low", stuck, 8'h7F);
        repeat (7) @(negedge clk); chk("stuck_reset", stuck, 8'hFF);
        tick(1);
        clr = 1'b1;
        lim = 8'd0;
        tick(1);
        clr = 1'b0;
        @(negedge clk); chk("stuck_clr", stuck, 8'h00);
        repeat (5) @(negedge clk); chk("stuck_clr_hold", stuck, 8'h00);
        wait_drain(10);

        // Lane changing again in its grant cycle: pushed, then reloaded without overflow.
        tick(1);
        st[1] = B;
        tick(1);
        st[1] = C; st[2] = C;
        sb_q.push_back(ev(1, A, B));
        sb_q.push_back(ev(2, B, C));
        sb_q.push_back(ev(1, B, C));
        wait_drain(20);
        chk("regrant_no_ovf", ovf, 1'b0);

        // Reset with three events queued discards them.
        tick(1);
        evt_if.I_EVT_READY = 1'b0;
        st[3] = C; st[4] = C; st[5] = C;
        tick(6);
        @(negedge clk); chk("queued_valid", evt_if.O_EVT_VALID, 1'b1);
        rstn = 1'b0;
        for (int i = 0; i < NL; i++) st[i] = A;
        #1;
        chk("rst_async_valid", evt_if.O_EVT_VALID, 1'b0);
        @(negedge clk); chk("rst_hold_valid", evt_if.O_EVT_VALID, 1'b0);
        tick(1);
        rstn = 1'b1;
        evt_if.I_EVT_READY = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_valid", evt_if.O_EVT_VALID, 1'b0);
        chk("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
